// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Purpose  : Shared types for the conditional-branch resolver: ARM condition
//            codes, NZVC flag bit positions and the resolver state encoding.
// Revision : 1.0  initial release
// ============================================================================
package cond_pkg;

  // ARM B.cond condition field encoding
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cc_e;

  // Bit positions inside the packed {N,Z,V,C} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // IDLE accepts branches; WAIT holds one branch until the flags settle
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cond_branch_resolver_if.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_resolver_if
// Purpose  : Branch request / branch result bundle between the ID-stage
//            branch logic (master) and the resolver (slave).
// Revision : 1.0  initial release
// ============================================================================
interface cond_branch_resolver_if #(
  parameter int CC_W  = 4,
  parameter int TAG_W = 5
);

  logic             br_valid;
  logic             br_ready;
  logic [CC_W-1:0]  br_cond;
  logic [TAG_W-1:0] br_tag;
  logic             res_valid;
  logic             res_taken;
  logic [TAG_W-1:0] res_tag;

  // ID-stage side: presents branches, observes the redirect result
  modport master (
    output br_valid, br_cond, br_tag,
    input  br_ready, res_valid, res_taken, res_tag
  );

  // Resolver side
  modport slave (
    input  br_valid, br_cond, br_tag,
    output br_ready, res_valid, res_taken, res_tag
  );

endinterface
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Purely combinational ARM condition-code evaluator
//            (condition code + {N,Z,V,C} -> taken).
// Revision : 1.0  initial release
// ============================================================================
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [3:0] flags,
  output logic       taken
);

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_c;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_v = flags[FLAG_V];
  assign w_c = flags[FLAG_C];

  // Decode the condition against the supplied flags; AL and NV both always pass
  always_comb begin
    taken = 1'b0;
    case (cc_e'(cc))
      EQ:      taken = w_z;
      NE:      taken = ~w_z;
      HS:      taken = w_c;
      LO:      taken = ~w_c;
      MI:      taken = w_n;
      PL:      taken = ~w_n;
      VS:      taken = w_v;
      VC:      taken = ~w_v;
      HI:      taken = w_c & ~w_z;
      LS:      taken = ~w_c | w_z;
      GE:      taken = (w_n == w_v);
      LT:      taken = (w_n != w_v);
      GT:      taken = ~w_z & (w_n == w_v);
      LE:      taken = w_z | (w_n != w_v);
      AL:      taken = 1'b1;
      NV:      taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : cond_branch_resolver
// Purpose  : Holds the architectural NZVC register and resolves B.cond
//            branches against the youngest flags, bypassing from EX. A branch
//            whose flag setter is still busy in EX is parked in WAIT until
//            the ALU flags settle.
// Revision : 1.0  initial release
// ============================================================================
module cond_branch_resolver
  import cond_pkg::*;
#(
  parameter int CC_W  = 4,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_setflags,
  input  logic                   ex_flags_valid,
  input  logic [3:0]             ex_flags,
  input  logic                   flush,
  cond_branch_resolver_if.slave  bus,
  output logic [3:0]             flags_q
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_flags;
  logic [CC_W-1:0]  r_cond;
  logic [TAG_W-1:0] r_tag;
  logic             r_res_valid;
  logic             r_res_taken;
  logic [TAG_W-1:0] r_res_tag;

  logic             w_flag_wr;
  logic             w_pending;
  logic [3:0]       w_eff_flags;
  logic             w_live_taken;
  logic             w_held_taken;
  logic             w_latch;
  logic             w_emit;
  logic             w_emit_taken;
  logic [TAG_W-1:0] w_emit_tag;

  // A setter whose flags are not yet settled blocks immediate resolution
  assign w_flag_wr   = ex_setflags & ex_flags_valid;
  assign w_pending   = ex_setflags & ~ex_flags_valid;
  assign w_eff_flags = w_flag_wr ? ex_flags : r_flags;

  // Live branch: evaluated against bypassed-or-architectural flags
  cond_eval u_eval_live (
    .cc    (bus.br_cond),
    .flags (w_eff_flags),
    .taken (w_live_taken)
  );

  // Parked branch: evaluated against the ALU flags as they settle
  cond_eval u_eval_held (
    .cc    (r_cond),
    .flags (ex_flags),
    .taken (w_held_taken)
  );

  // Architectural flag register; flush never touches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_flag_wr) begin
      r_flags <= ex_flags;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the emit/park decisions; flush wins over everything
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_emit       = 1'b0;
    w_emit_taken = 1'b0;
    w_emit_tag   = '0;
    case (r_state)
      IDLE: begin
        if (bus.br_valid && !flush) begin
          if (w_pending) begin
            w_latch     = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_emit       = 1'b1;
            w_emit_taken = w_live_taken;
            w_emit_tag   = bus.br_tag;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (ex_flags_valid) begin
          w_emit       = 1'b1;
          w_emit_taken = w_held_taken;
          w_emit_tag   = r_tag;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Park the branch while its flags are outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond <= '0;
      r_tag  <= '0;
    end else if (w_latch) begin
      r_cond <= bus.br_cond;
      r_tag  <= bus.br_tag;
    end
  end

  // Result register: single-cycle valid pulse, taken/tag hold between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_taken <= 1'b0;
      r_res_tag   <= '0;
    end else begin
      r_res_valid <= w_emit;
      if (w_emit) begin
        r_res_taken <= w_emit_taken;
        r_res_tag   <= w_emit_tag;
      end
    end
  end

  assign bus.br_ready  = (r_state == IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_taken = r_res_taken;
  assign bus.res_tag   = r_res_tag;
  assign flags_q       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_cond_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_branch_resolver
// Purpose  : Self-checking bench: directed multi-cycle sequences plus a
//            table sweep of all condition/flag combinations; results are
//            matched against a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_cond_branch_resolver;
  import cond_pkg::*;

  localparam int CC_W  = 4;
  localparam int TAG_W = 5;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  typedef struct {
    logic             taken;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       ex_setflags;
  logic       ex_flags_valid;
  logic [3:0] ex_flags;
  logic       flush;
  logic [3:0] flags_q;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  vec_t vecs[256];

  cond_branch_resolver_if #(.CC_W(CC_W), .TAG_W(TAG_W)) bif ();

  cond_branch_resolver #(.CC_W(CC_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_setflags    (ex_setflags),
    .ex_flags_valid (ex_flags_valid),
    .ex_flags       (ex_flags),
    .flush          (flush),
    .bus            (bif),
    .flags_q        (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode built from the ARM pair structure: cond[3:1] picks a
  // base test, cond[0] inverts it except for the AL/NV pair.
  function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && (c[3:1] != 3'd7)) ? ~base : base;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic taken, input logic [TAG_W-1:0] tag);
    res_t r;
    r.taken = taken;
    r.tag   = tag;
    sb.push_back(r);
  endtask

  // Scoreboard monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bif.res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_valid=1 tag=%0d expected no result", bif.res_tag);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("sb_taken", {31'd0, bif.res_taken}, {31'd0, e.taken});
        check("sb_tag", {27'd0, bif.res_tag}, {27'd0, e.tag});
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    ex_setflags    = 1'b0;
    ex_flags_valid = 1'b0;
    ex_flags       = 4'b0000;
    flush          = 1'b0;
    bif.br_valid   = 1'b0;
    bif.br_cond    = '0;
    bif.br_tag     = '0;

    for (int i = 0; i < 256; i++) begin
      vecs[i].cond  = i[7:4];
      vecs[i].flags = i[3:0];
      vecs[i].exp   = ref_taken(i[7:4], i[3:0]);
    end

    // Reset state
    #12;
    check("rst_flags_q", {28'd0, flags_q}, 32'd0);
    check("rst_res_valid", {31'd0, bif.res_valid}, 32'd0);
    check("rst_res_taken", {31'd0, bif.res_taken}, 32'd0);
    check("rst_res_tag", {27'd0, bif.res_tag}, 32'd0);
    check("rst_br_ready", {31'd0, bif.br_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // EQ with no setter, flags 0000 -> not taken
    bif.br_valid = 1'b1; bif.br_cond = EQ; bif.br_tag = 5'd1;
    expect_result(1'b0, 5'd1);
    tick();
    bif.br_valid = 1'b0;
    check("s1_res_valid", {31'd0, bif.res_valid}, 32'd1);
    check("s1_res_taken", {31'd0, bif.res_taken}, 32'd0);
    check("s1_flags_q", {28'd0, flags_q}, 32'd0);
    tick();
    check("s1_pulse_ends", {31'd0, bif.res_valid}, 32'd0);

    // Same-cycle bypass of Z into an EQ branch
    ex_setflags = 1'b1; ex_flags_valid = 1'b1; ex_flags = 4'b0100;
    bif.br_valid = 1'b1; bif.br_cond = EQ; bif.br_tag = 5'd7;
    expect_result(1'b1, 5'd7);
    tick();
    ex_setflags = 1'b0; ex_flags_valid = 1'b0; bif.br_valid = 1'b0;
    check("s2_res_valid", {31'd0, bif.res_valid}, 32'd1);
    check("s2_res_taken", {31'd0, bif.res_taken}, 32'd1);
    check("s2_res_tag", {27'd0, bif.res_tag}, 32'd7);
    check("s2_flags_q", {28'd0, flags_q}, 32'h4);

    // Multi-cycle setter: LT waits three cycles, then N=1,V=0 -> taken
    ex_setflags = 1'b1; ex_flags_valid = 1'b0; ex_flags = 4'b0000;
    bif.br_valid = 1'b1; bif.br_cond = LT; bif.br_tag = 5'd3;
    tick();
    bif.br_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("s3_ready_low", {31'd0, bif.br_ready}, 32'd0);
      check("s3_no_result", {31'd0, bif.res_valid}, 32'd0);
      if (k < 2) tick();
    end
    ex_flags_valid = 1'b1; ex_flags = 4'b1000;
    expect_result(1'b1, 5'd3);
    tick();
    ex_setflags = 1'b0; ex_flags_valid = 1'b0;
    check("s3_res_valid", {31'd0, bif.res_valid}, 32'd1);
    check("s3_res_tag", {27'd0, bif.res_tag}, 32'd3);
    check("s3_ready_back", {31'd0, bif.br_ready}, 32'd1);
    check("s3_flags_q", {28'd0, flags_q}, 32'h8);

    // Flush while parked: no result, flags still land afterwards
    ex_setflags = 1'b1; ex_flags_valid = 1'b0;
    bif.br_valid = 1'b1; bif.br_cond = EQ; bif.br_tag = 5'd9;
    tick();
    bif.br_valid = 1'b0;
    check("s4_ready_low", {31'd0, bif.br_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("s4_ready_after_flush", {31'd0, bif.br_ready}, 32'd1);
    check("s4_no_result", {31'd0, bif.res_valid}, 32'd0);
    ex_flags_valid = 1'b1; ex_flags = 4'b0011;
    tick();
    ex_setflags = 1'b0; ex_flags_valid = 1'b0;
    check("s4_flags_q", {28'd0, flags_q}, 32'h3);
    check("s4_still_no_result", {31'd0, bif.res_valid}, 32'd0);

    // Flush arriving together with the settling flags suppresses the result
    ex_setflags = 1'b1; ex_flags_valid = 1'b0;
    bif.br_valid = 1'b1; bif.br_cond = AL; bif.br_tag = 5'd11;
    tick();
    bif.br_valid = 1'b0;
    flush = 1'b1; ex_flags_valid = 1'b1; ex_flags = 4'b0101;
    tick();
    flush = 1'b0; ex_setflags = 1'b0; ex_flags_valid = 1'b0;
    check("s5_suppressed", {31'd0, bif.res_valid}, 32'd0);
    check("s5_ready", {31'd0, bif.br_ready}, 32'd1);
    check("s5_flags_q", {28'd0, flags_q}, 32'h5);

    // Flush together with br_valid in IDLE drops the branch
    bif.br_valid = 1'b1; bif.br_cond = AL; bif.br_tag = 5'd12; flush = 1'b1;
    tick();
    bif.br_valid = 1'b0; flush = 1'b0;
    check("s6_dropped", {31'd0, bif.res_valid}, 32'd0);

    // Full sweep: preload flags_q, then branch with no setter in EX
    for (int i = 0; i < 256; i++) begin
      ex_setflags = 1'b1; ex_flags_valid = 1'b1; ex_flags = vecs[i].flags;
      tick();
      ex_setflags = 1'b0; ex_flags_valid = 1'b0;
      check("sweep_preload", {28'd0, flags_q}, {28'd0, vecs[i].flags});
      bif.br_valid = 1'b1; bif.br_cond = vecs[i].cond; bif.br_tag = i[4:0];
      expect_result(vecs[i].exp, i[4:0]);
      tick();
      bif.br_valid = 1'b0;
      check("sweep_taken", {31'd0, bif.res_taken}, {31'd0, vecs[i].exp});
    end

    // Asynchronous reset between edges while a branch is parked
    ex_setflags = 1'b1; ex_flags_valid = 1'b1; ex_flags = 4'b1111;
    tick();
    ex_flags_valid = 1'b0;
    bif.br_valid = 1'b1; bif.br_cond = AL; bif.br_tag = 5'd21;
    tick();
    bif.br_valid = 1'b0;
    check("s7_parked", {31'd0, bif.br_ready}, 32'd0);
    check("s7_flags_before", {28'd0, flags_q}, 32'hF);
    #2;
    rst_n = 1'b0;
    ex_setflags = 1'b0;
    #1;
    check("s7_async_flags", {28'd0, flags_q}, 32'd0);
    check("s7_async_valid", {31'd0, bif.res_valid}, 32'd0);
    check("s7_async_taken", {31'd0, bif.res_taken}, 32'd0);
    check("s7_async_tag", {27'd0, bif.res_tag}, 32'd0);
    check("s7_async_ready", {31'd0, bif.br_ready}, 32'd1);
    tick();
    #2;
    rst_n = 1'b1;
    ex_flags_valid = 1'b1; ex_flags = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s7_no_result", {31'd0, bif.res_valid}, 32'd0);
      check("s7_ready", {31'd0, bif.br_ready}, 32'd1);
    end
    ex_flags_valid = 1'b0;
    check("s7_flags_q", {28'd0, flags_q}, 32'd0);

    tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_branch_resolver.md
Name: cond_branch_resolver

Overview:
- Consumer end of the 64-bit ALU flag interface: `negative`, `zero`, `overflow`, `carry_out`.
- Holds the architectural NZVC flag register, written by flag-setting instructions (ADDS/SUBS/ANDS) in EX.
- Resolves B.cond branches against the youngest flag values, bypassing from EX when the setter is one stage ahead.
- Sits between the ID-stage branch logic and the EX-stage ALU; drives the taken/not-taken redirect to fetch.

Parameters:
- CC_W, 4, width of the B.cond condition field.
- TAG_W, 5, width of the branch tag echoed with the result.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_setflags  input  1  the EX instruction writes flags.
- ex_flags_valid  input  1  EX flag outputs are settled this cycle. Low for multi-cycle EX ops.
- ex_flags  input  4  {N,Z,V,C} from the ALU.
- br_valid  input  1  B.cond presented from ID.
- br_ready  output  1  resolver can accept a branch this cycle.
- br_cond  input  CC_W  condition code.
- br_tag  input  TAG_W  branch identifier.
- flush  input  1  pipeline flush; kills the in-flight branch.
- res_valid  output  1  one-cycle pulse, result available.
- res_taken  output  1  condition true.
- res_tag  output  TAG_W  tag of the resolved branch.
- flags_q  output  4  architectural {N,Z,V,C}.

Behaviour:
- Reset (async, rst_n=0): flags_q=4'b0000, state=IDLE, res_valid=0, res_taken=0, res_tag=0. br_ready follows the state, so it is 1 in IDLE.
- Flag register: on a clk edge with ex_setflags && ex_flags_valid, flags_q <= ex_flags. Otherwise flags_q holds. flush does not affect flags_q.
- Effective flags: eff = (ex_setflags && ex_flags_valid) ? ex_flags : flags_q. This is same-cycle bypass.
- Pending condition: pending = ex_setflags && !ex_flags_valid.
- FSM states: IDLE, WAIT.
  - IDLE, br_valid && !flush && !pending: evaluate with eff. Next edge sets res_valid=1, res_taken=eval, res_tag=br_tag. Stay IDLE.
  - IDLE, br_valid && !flush && pending: latch br_cond/br_tag, go to WAIT. No result.
  - WAIT: br_ready=0. When ex_flags_valid: evaluate latched cond with ex_flags, emit result next edge, return to IDLE.
  - WAIT with flush: return to IDLE, no result.
  - br_ready=1 only in IDLE.
- Latency: 1 cycle from acceptance when flags are ready. Otherwise 1 cycle after ex_flags_valid rises.
- res_valid is a single-cycle pulse; there is no backpressure.
- flush and br_valid together in IDLE: the branch is dropped.
- A flush in the cycle a result is being registered suppresses it: res_valid=0.
- Condition decode (ARM):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 1
- Reset asserted mid-WAIT: immediate return to IDLE, outputs cleared, latched branch discarded.

Decomposition:
- Shared package cond_pkg holds:
  - the cc_e enum (EQ..NV, 4 bits);
  - the flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
  - the state enum {IDLE, WAIT}.
- One combinational sub-module, cond_eval (cc, flags -> taken), is instantiated twice: once on the live branch, once on the latched branch.

Test Plan:
- Reset, then br_valid with cond=EQ and no setter -> res_valid pulse next cycle, res_taken=0 (flags 0000), flags_q=0000.
- ex_setflags=1, ex_flags_valid=1, ex_flags=0100 (Z), with a same-cycle br_valid cond=EQ tag=7 -> next cycle res_taken=1, res_tag=7, flags_q=0100.
- Setter with ex_flags_valid=0 for 3 cycles, branch cond=LT tag=3, then flags 1000 -> br_ready=0 for 3 cycles, then res_taken=1, res_tag=3 the cycle after valid.
- In WAIT, assert flush -> no res_valid, state IDLE, br_ready=1 next cycle. Then ex_flags arrive and still update flags_q.
- Sweep all 16 conditions over all 16 flag values with flags_q preloaded -> res_taken matches the decode table for all 256 cases.
- Drop rst_n asynchronously mid-WAIT between clock edges -> outputs and flags_q go to 0 immediately, with no result after release.
